taxi_xgmii_link_fault_ctrl: RTL and testbench
=============================================

TAXI_XGMII_LINK_FAULT_CTRL -- requirements
Module: taxi_xgmii_link_fault_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 64, XGMII width; only 64 is legal, otherwise elaboration fatal.
REQ-002 SHALL have parameter COL_WINDOW, default 128, max columns allowed between consecutive fault sequences.
REQ-003 SHALL have parameter SEQ_THRESH, default 4, consecutive same-type sequences needed to declare a fault.
REQ-004 SHALL have parameter CNT_W, default 16, statistics counter width.
REQ-005 SHALL have port clk  in  1  clock; reset rst, synchronous, active-high.
REQ-006 SHALL have port rst  in  1  synchronous active-high reset.
REQ-007 SHALL have port xgmii_rxd  in  64  XGMII receive data, same bus as the frame receiver sees.
REQ-008 SHALL have port xgmii_rxc  in  8  XGMII receive control.
REQ-009 SHALL have port cfg_rx_enable  in  1  software receive enable.
REQ-010 SHALL have port stat_clear  in  1  single-cycle clear of the event counters.
REQ-011 SHALL have port rx_enable  out  1  gated enable for the frame receiver's cfg_rx_enable.
REQ-012 SHALL have port link_status  out  2  00 OK, 01 local fault, 10 remote fault.
REQ-013 SHALL have port tx_fault_mode  out  2  00 normal, 01 send remote fault, 10 send idle.
REQ-014 SHALL have ports stat_local_fault_cnt and stat_remote_fault_cnt  out  CNT_W  saturating counts of fault declarations.

Function
REQ-015 SHALL split each cycle into column 0 (lanes 0-3) and column 1 (lanes 4-7), and process column 0 then column 1 within the same cycle.
REQ-016 SHALL classify a column as a LF sequence when rxc nibble = 0001, lane0 = 0x9C, lanes1..3 = 0x00,0x00,0x01.
REQ-017 SHALL classify a column as a RF sequence under the same rule with lane3 = 0x02; every other column is non-fault.
REQ-018 On a fault column of the same type as last_type with col_cnt < COL_WINDOW, SHALL increment seq_cnt (saturating at SEQ_THRESH); otherwise set seq_cnt = 1 and last_type = the new type; col_cnt SHALL be set to 0.
REQ-019 On a non-fault column, SHALL increment col_cnt, saturating at COL_WINDOW.
REQ-020 SHALL declare a fault in state LOCAL or REMOTE, per last_type, when seq_cnt reaches SEQ_THRESH.
REQ-021 SHALL return to OK and zero seq_cnt when col_cnt reaches COL_WINDOW.
REQ-022 SHALL use FSM states OK, LOCAL and REMOTE.
  - Direct LOCAL<->REMOTE transitions are allowed per REQ-020.
  - Re-declaring the current state is not a new event.
REQ-023 SHALL register link_status one cycle after the cycle containing the triggering column.
REQ-024 SHALL drive tx_fault_mode = 01 when link_status = LOCAL, 10 when REMOTE, and 00 when OK, in the same cycle as link_status.
REQ-025 SHALL track in_frame as follows:
  - set by 0xFB with rxc in lane 0 or lane 4;
  - cleared by 0xFD with rxc in any lane at or after the start;
  - cleared by any fault column.
REQ-026 SHALL target rx_enable = cfg_rx_enable && (link_status == OK).
  - rx_enable SHALL update only in cycles where in_frame is 0 and no start is present.
  - A change requested mid-frame SHALL take effect the cycle after the frame's terminate cycle.
REQ-027 SHALL increment a counter by 1 on each transition into LOCAL or REMOTE, saturating at all-ones.
REQ-028 On stat_clear, SHALL zero both counters; a simultaneous event SHALL leave the count at 1.

Reset
REQ-029 On rst, SHALL set:
  - link_status = OK, tx_fault_mode = 00, rx_enable = 0;
  - both counters = 0;
  - seq_cnt = 0, col_cnt = COL_WINDOW, last_type = LF, in_frame = 0.
REQ-030 After rst deasserts, SHALL let rx_enable follow cfg_rx_enable from the first idle cycle; a reset mid-frame SHALL abandon that frame's tracking.

Structure
REQ-031 SHALL place the XGMII characters (IDLE 07, START FB, TERM FD, ERROR FE, SEQ 9C) and the link-status enum in package taxi_xgmii_pkg.
REQ-032 SHALL implement the per-column LF/RF/start/terminate decode as sub-module taxi_xgmii_col_classify, instantiated twice.

Verification
REQ-033 4 LF columns spaced 10 columns apart -> link_status=01, tx_fault_mode=01, rx_enable=0, stat_local_fault_cnt=1.
REQ-034 4 LF columns with a 128-column gap before the fourth -> link_status stays 00.
REQ-035 From LOCAL, 128 idle columns (64 cycles) -> link_status=00 on the next cycle, rx_enable=1 with cfg_rx_enable=1.
REQ-036 LF,LF,RF,RF,RF,RF -> link_status=10, tx_fault_mode=10, remote count=1, local count=0.
REQ-037 cfg_rx_enable dropped during a 3-cycle frame with lane-4 start -> rx_enable falls only the cycle after the terminate cycle.
REQ-038 Remote counter at 0xFFFF plus a new RF declaration -> stays 0xFFFF; stat_clear with a simultaneous declaration -> 1.

Source files
------------

// File: rtl/taxi_xgmii_pkg.sv
// XGMII character codes, link-fault types and helpers shared by the
// link-fault controller and its column classifier.
package taxi_xgmii_pkg;

    // XGMII control characters
    localparam logic [7:0] XGMII_IDLE  = 8'h07;
    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_ERROR = 8'hFE;
    localparam logic [7:0] XGMII_SEQ   = 8'h9C;

    // Lane-3 code of a sequence ordered set that identifies the fault type
    localparam logic [7:0] SEQ_CODE_LF = 8'h01;
    localparam logic [7:0] SEQ_CODE_RF = 8'h02;

    typedef enum logic [1:0] {
        LINK_OK     = 2'b00,
        LINK_LOCAL  = 2'b01,
        LINK_REMOTE = 2'b10
    } link_status_e;

    typedef enum logic {
        FAULT_LF = 1'b0,
        FAULT_RF = 1'b1
    } fault_type_e;

    typedef enum logic [1:0] {
        TX_NORMAL    = 2'b00,
        TX_SEND_RF   = 2'b01,
        TX_SEND_IDLE = 2'b10
    } tx_fault_mode_e;

    // Link state declared by a run of sequences of the given type
    function automatic link_status_e fault_state(input fault_type_e t);
        return (t == FAULT_RF) ? LINK_REMOTE : LINK_LOCAL;
    endfunction

    // A local fault answers with remote-fault sequences; a remote fault
    // answers by sending idles instead of frames.
    function automatic tx_fault_mode_e tx_mode_for(input link_status_e s);
        case (s)
            LINK_LOCAL:  return TX_SEND_RF;
            LINK_REMOTE: return TX_SEND_IDLE;
            default:     return TX_NORMAL;
        endcase
    endfunction

endpackage

// File: rtl/taxi_xgmii_col_classify.sv
// Decodes one 4-lane XGMII column: local/remote fault sequence ordered
// sets, a start character in the column's first lane, and a terminate
// character in any lane.
module taxi_xgmii_col_classify
    import taxi_xgmii_pkg::*;
(
    input  logic [31:0] col_rxd,
    input  logic [3:0]  col_rxc,
    output logic        is_lf,
    output logic        is_rf,
    output logic        is_start,
    output logic        is_term
);

    logic seq_hdr;

    // Sequence ordered set: only lane 0 is control, 9C followed by 00 00
    assign seq_hdr = (col_rxc == 4'b0001) && (col_rxd[7:0] == XGMII_SEQ) &&
                     (col_rxd[15:8] == 8'h00) && (col_rxd[23:16] == 8'h00);

    assign is_lf    = seq_hdr && (col_rxd[31:24] == SEQ_CODE_LF);
    assign is_rf    = seq_hdr && (col_rxd[31:24] == SEQ_CODE_RF);
    assign is_start = col_rxc[0] && (col_rxd[7:0] == XGMII_START);

    // Terminate may sit in any lane of the column
    always_comb begin
        // NOTE: every signal written in always_comb gets a default first so no path leaves it unassigned (which would infer a latch).
        is_term = 1'b0;
        for (int lane = 0; lane < 4; lane++) begin
            if (col_rxc[lane] && (col_rxd[8*lane +: 8] == XGMII_TERM)) begin
                is_term = 1'b1;
            end
        end
    end

endmodule

// File: rtl/taxi_xgmii_link_fault_ctrl.sv
// XGMII link-fault state machine: counts runs of local/remote fault
// sequences on the receive bus, declares link status, steers the
// transmitter's fault response and gates the frame receiver's enable on
// frame boundaries.
module taxi_xgmii_link_fault_ctrl
    import taxi_xgmii_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int COL_WINDOW = 128,
    parameter int SEQ_THRESH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   xgmii_rxd,
    input  logic [DATA_W/8-1:0] xgmii_rxc,
    input  logic                cfg_rx_enable,
    input  logic                stat_clear,
    output logic                rx_enable,
    output logic [1:0]          link_status,
    output logic [1:0]          tx_fault_mode,
    output logic [CNT_W-1:0]    stat_local_fault_cnt,
    output logic [CNT_W-1:0]    stat_remote_fault_cnt
);

    if (DATA_W != 64) begin : g_data_w_check
        $fatal(1, "taxi_xgmii_link_fault_ctrl: DATA_W must be 64");
    end

    localparam int COL_W = $clog2(COL_WINDOW + 1);
    localparam int SEQ_W = $clog2(SEQ_THRESH + 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(COL_WINDOW);
    localparam logic [SEQ_W-1:0] SEQ_MAX = SEQ_W'(SEQ_THRESH);

    logic [1:0] col_lf;
    logic [1:0] col_rf;
    logic [1:0] col_start;
    logic [1:0] col_term;

    for (genvar c = 0; c < 2; c++) begin : g_col
        taxi_xgmii_col_classify u_classify (
            .col_rxd  (xgmii_rxd[32*c +: 32]),
            .col_rxc  (xgmii_rxc[4*c +: 4]),
            .is_lf    (col_lf[c]),
            .is_rf    (col_rf[c]),
            .is_start (col_start[c]),
            .is_term  (col_term[c])
        );
    end

    link_status_e     state_q, state_d;
    fault_type_e      last_type_q, last_type_d;
    logic [SEQ_W-1:0] seq_cnt_q, seq_cnt_d;
    logic [COL_W-1:0] col_cnt_q, col_cnt_d;
    logic             in_frame_q, in_frame_d;
    fault_type_e      col_type;
    logic             local_event;
    logic             remote_event;
    logic             rx_en_update;
    logic             rx_en_target;

    // State register for the fault FSM and its run/window counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LINK_OK;
            last_type_q <= FAULT_LF;
            seq_cnt_q   <= '0;
            col_cnt_q   <= COL_MAX;
            in_frame_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples its pre-edge inputs.
            state_q     <= state_d;
            last_type_q <= last_type_d;
            seq_cnt_q   <= seq_cnt_d;
            col_cnt_q   <= col_cnt_d;
            in_frame_q  <= in_frame_d;
        end
    end

    // Walk column 0 then column 1, carrying counters and frame state across
    always_comb begin
        state_d     = state_q;
        last_type_d = last_type_q;
        seq_cnt_d   = seq_cnt_q;
        col_cnt_d   = col_cnt_q;
        in_frame_d  = in_frame_q;
        col_type    = FAULT_LF;
        // NOTE: blocking assignments here are deliberate: column 1 must see the values column 0 just produced.
        for (int c = 0; c < 2; c++) begin
            if (col_lf[c] || col_rf[c]) begin
                col_type = col_rf[c] ? FAULT_RF : FAULT_LF;
                if ((col_type == last_type_d) && (col_cnt_d < COL_MAX)) begin
                    if (seq_cnt_d < SEQ_MAX) begin
                        seq_cnt_d = seq_cnt_d + SEQ_W'(1);
                    end
                end else begin
                    seq_cnt_d   = SEQ_W'(1);
                    last_type_d = col_type;
                end
                col_cnt_d  = '0;
                in_frame_d = 1'b0;
            end else begin
                if (col_cnt_d < COL_MAX) begin
                    col_cnt_d = col_cnt_d + COL_W'(1);
                end
                // A start only ever sits in lane 0, so a terminate in the
                // same column always follows it and wins.
                if (col_start[c]) begin
                    in_frame_d = 1'b1;
                end
                if (col_term[c]) begin
                    in_frame_d = 1'b0;
                end
            end
            if (seq_cnt_d == SEQ_MAX) begin
                state_d = fault_state(last_type_d);
            end
            if (col_cnt_d == COL_MAX) begin
                state_d   = LINK_OK;
                seq_cnt_d = '0;
            end
        end
    end

    // Only entries into a fault state count; holding the same state does not
    assign local_event  = (state_d == LINK_LOCAL)  && (state_q != LINK_LOCAL);
    assign remote_event = (state_d == LINK_REMOTE) && (state_q != LINK_REMOTE);

    // The enable target follows the status being registered this edge, and
    // may only move when no frame is open at the end of the cycle and none
    // is starting in it, so the receiver never sees a partial frame.
    assign rx_en_target = cfg_rx_enable && (state_d == LINK_OK);
    assign rx_en_update = !in_frame_d && !(|col_start);

    // Frame-boundary gated receive enable
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_enable <= 1'b0;
        end else if (rx_en_update) begin
            rx_enable <= rx_en_target;
        end
    end

    function automatic logic [CNT_W-1:0] count_next(input logic [CNT_W-1:0] cnt,
                                                    input logic             event_hit,
                                                    input logic             clear);
        if (clear) begin
            return event_hit ? CNT_W'(1) : '0;
        end
        if (event_hit && (cnt != '1)) begin
            return cnt + CNT_W'(1);
        end
        return cnt;
    endfunction

    // Saturating fault-declaration counters with clear-and-count priority
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_local_fault_cnt  <= '0;
            stat_remote_fault_cnt <= '0;
        end else begin
            stat_local_fault_cnt  <= count_next(stat_local_fault_cnt, local_event, stat_clear);
            stat_remote_fault_cnt <= count_next(stat_remote_fault_cnt, remote_event, stat_clear);
        end
    end

    // Outputs derived from the registered link state
    always_comb begin
        link_status   = state_q;
        tx_fault_mode = tx_mode_for(state_q);
    end

endmodule

// File: tb/tb_taxi_xgmii_link_fault_ctrl.sv
// Self-checking bench for taxi_xgmii_link_fault_ctrl: directed scenarios
// with literal expectations plus a long randomized run compared every
// cycle against a column-level behavioural model.
module tb_taxi_xgmii_link_fault_ctrl;

    localparam int COL_WINDOW = 128;
    localparam int SEQ_THRESH = 4;
    // Narrow counters so saturation is reachable in a short run
    localparam int CNT_W      = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic [63:0]      xgmii_rxd;
    logic [7:0]       xgmii_rxc;
    logic             cfg_rx_enable;
    logic             stat_clear;
    logic             rx_enable;
    logic [1:0]       link_status;
    logic [1:0]       tx_fault_mode;
    logic [CNT_W-1:0] stat_local_fault_cnt;
    logic [CNT_W-1:0] stat_remote_fault_cnt;

    taxi_xgmii_link_fault_ctrl #(
        .DATA_W     (64),
        .COL_WINDOW (COL_WINDOW),
        .SEQ_THRESH (SEQ_THRESH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .xgmii_rxd             (xgmii_rxd),
        .xgmii_rxc             (xgmii_rxc),
        .cfg_rx_enable         (cfg_rx_enable),
        .stat_clear            (stat_clear),
        .rx_enable             (rx_enable),
        .link_status           (link_status),
        .tx_fault_mode         (tx_fault_mode),
        .stat_local_fault_cnt  (stat_local_fault_cnt),
        .stat_remote_fault_cnt (stat_remote_fault_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    // Values applied to the DUT at the next driven cycle
    bit tb_rst = 1'b1;
    bit tb_cfg = 1'b1;
    bit tb_clr = 1'b0;

    // Behavioural model: link state 0 OK / 1 local / 2 remote
    int m_state, m_run_len, m_run_type, m_gap;
    int m_in_frame, m_rx_en, m_lcnt, m_rcnt;
    bit model_valid = 1'b0;

    function automatic int fault_kind(input logic [31:0] d, input logic [3:0] c);
        // 0 none, 1 LF, 2 RF
        if (c == 4'b0001 && d[7:0] == 8'h9C && d[15:8] == 8'h00 && d[23:16] == 8'h00) begin
            if (d[31:24] == 8'h01) return 1;
            if (d[31:24] == 8'h02) return 2;
        end
        return 0;
    endfunction

    task automatic model_cycle(input logic [63:0] d, input logic [7:0] c);
        int prev_state;
        bit start_any;
        int kind;
        logic [31:0] cd;
        logic [3:0]  cc;
        if (tb_rst) begin
            m_state = 0; m_run_len = 0; m_run_type = 1; m_gap = COL_WINDOW;
            m_in_frame = 0; m_rx_en = 0; m_lcnt = 0; m_rcnt = 0;
            return;
        end
        prev_state = m_state;
        start_any  = 1'b0;
        for (int col = 0; col < 2; col++) begin
            cd   = d[32*col +: 32];
            cc   = c[4*col +: 4];
            kind = fault_kind(cd, cc);
            if (kind != 0) begin
                // A run continues only with the same type inside the window
                if (kind == m_run_type && m_gap < COL_WINDOW) m_run_len++;
                else begin
                    m_run_len  = 1;
                    m_run_type = kind;
                end
                m_gap      = 0;
                m_in_frame = 0;
                if (m_run_len >= SEQ_THRESH) m_state = kind;
            end else begin
                m_gap++;
                if (m_gap >= COL_WINDOW) begin
                    m_state   = 0;
                    m_run_len = 0;
                end
                for (int k = 0; k < 4; k++) begin
                    if (cc[k] && k == 0 && cd[7:0] == 8'hFB) begin
                        m_in_frame = 1;
                        start_any  = 1'b1;
                    end
                    if (cc[k] && cd[8*k +: 8] == 8'hFD) m_in_frame = 0;
                end
            end
        end
        if (tb_clr) begin
            m_lcnt = (m_state == 1 && prev_state != 1) ? 1 : 0;
            m_rcnt = (m_state == 2 && prev_state != 2) ? 1 : 0;
        end else begin
            if (m_state == 1 && prev_state != 1 && m_lcnt < CNT_MAX) m_lcnt++;
            if (m_state == 2 && prev_state != 2 && m_rcnt < CNT_MAX) m_rcnt++;
        end
        if (m_in_frame == 0 && !start_any) m_rx_en = (tb_cfg && m_state == 0) ? 1 : 0;
    endtask

    function automatic int exp_tx(input int st);
        case (st)
            1:       return 1;   // local fault: send remote fault
            2:       return 2;   // remote fault: send idle
            default: return 0;
        endcase
    endfunction

    // One clock cycle of stimulus, applied at the falling edge
    task automatic drive(input logic [31:0] d0, input logic [3:0] c0,
                         input logic [31:0] d1, input logic [3:0] c1);
        @(negedge clk);
        xgmii_rxd     = {d1, d0};
        xgmii_rxc     = {c1, c0};
        rst           = tb_rst;
        cfg_rx_enable = tb_cfg;
        stat_clear    = tb_clr;
        model_cycle({d1, d0}, {c1, c0});
        model_valid = 1'b1;
    endtask

    task automatic settle();
        @(posedge clk);
        #3;
    endtask

    // Column queue for directed sequences
    logic [31:0] q_d[$];
    logic [3:0]  q_c[$];

    localparam logic [31:0] LF_D   = 32'h0100_009C;
    localparam logic [31:0] RF_D   = 32'h0200_009C;
    localparam logic [31:0] IDLE_D = 32'h0707_0707;

    task automatic push(input logic [31:0] d, input logic [3:0] c, input int n);
        for (int i = 0; i < n; i++) begin
            q_d.push_back(d);
            q_c.push_back(c);
        end
    endtask

    task automatic flush();
        logic [31:0] d0, d1;
        logic [3:0]  c0, c1;
        while (q_d.size() > 0) begin
            d0 = q_d.pop_front(); c0 = q_c.pop_front();
            if (q_d.size() > 0) begin
                d1 = q_d.pop_front(); c1 = q_c.pop_front();
            end else begin
                d1 = IDLE_D; c1 = 4'hF;
            end
            drive(d0, c0, d1, c1);
        end
    endtask

    task automatic rand_col(output logic [31:0] d, output logic [3:0] c);
        int sel, j;
        sel = $urandom_range(0, 99);
        d = $urandom();
        c = 4'h0;
        if (sel < 20)      begin d = LF_D;   c = 4'b0001; end
        else if (sel < 35) begin d = RF_D;   c = 4'b0001; end
        else if (sel < 62) begin d = IDLE_D; c = 4'hF;    end
        else if (sel < 72) begin d[7:0] = 8'hFB; c = 4'b0001; end
        else if (sel < 82) begin
            j = $urandom_range(0, 3);
            for (int k = 0; k < 4; k++) begin
                if (k == j)     begin d[8*k +: 8] = 8'hFD; c[k] = 1'b1; end
                else if (k > j) begin d[8*k +: 8] = 8'h07; c[k] = 1'b1; end
            end
        end
        else if (sel < 86) begin d = 32'h0300_009C; c = 4'b0001; end   // near-miss sequence
        else if (sel < 90) begin d = LF_D; c = 4'b0011; end            // wrong control mask
        else if (sel < 94) c = 4'($urandom());
        // else plain data with no control lanes
    endtask

    // Per-cycle comparison against the model
    initial begin
        wait (model_valid);
        forever begin
            @(posedge clk);
            #2;
            check("link_status",   32'(link_status),           32'(m_state));
            check("tx_fault_mode", 32'(tx_fault_mode),         32'(exp_tx(m_state)));
            check("rx_enable",     32'(rx_enable),             32'(m_rx_en));
            check("local_cnt",     32'(stat_local_fault_cnt),  32'(m_lcnt));
            check("remote_cnt",    32'(stat_remote_fault_cnt), 32'(m_rcnt));
        end
    end

    initial begin
        logic [31:0] d0, d1;
        logic [3:0]  c0, c1;
        rst = 1'b1; xgmii_rxd = '0; xgmii_rxc = '0; cfg_rx_enable = 1'b1; stat_clear = 1'b0;

        // Reset state
        tb_rst = 1'b1;
        drive(IDLE_D, 4'hF, IDLE_D, 4'hF);
        drive(IDLE_D, 4'hF, IDLE_D, 4'hF);
        settle();
        check("rst_link", 32'(link_status), 32'd0);
        check("rst_tx", 32'(tx_fault_mode), 32'd0);
        check("rst_rx_en", 32'(rx_enable), 32'd0);
        check("rst_lcnt", 32'(stat_local_fault_cnt), 32'd0);
        check("rst_rcnt", 32'(stat_remote_fault_cnt), 32'd0);
        tb_rst = 1'b0;
        drive(IDLE_D, 4'hF, IDLE_D, 4'hF);
        settle();
        check("first_idle_rx_en", 32'(rx_enable), 32'd1);

        // Four LF columns spaced ten columns apart
        for (int i = 0; i < 3; i++) begin
            push(LF_D, 4'b0001, 1);
            push(IDLE_D, 4'hF, 10);
        end
        push(LF_D, 4'b0001, 1);
        flush();
        settle();
        check("lf4_link", 32'(link_status), 32'd1);
        check("lf4_tx", 32'(tx_fault_mode), 32'd1);
        check("lf4_rx_en", 32'(rx_enable), 32'd0);
        check("lf4_lcnt", 32'(stat_local_fault_cnt), 32'd1);

        // Window expiry: 126 idle columns keep LOCAL, 128 return to OK
        push(IDLE_D, 4'hF, 126);
        flush();
        settle();
        check("win126_link", 32'(link_status), 32'd1);
        push(IDLE_D, 4'hF, 2);
        flush();
        settle();
        check("win128_link", 32'(link_status), 32'd0);
        check("win128_rx_en", 32'(rx_enable), 32'd1);

        // 128-column gap breaks the run; 127 does not
        push(LF_D, 4'b0001, 3);
        push(IDLE_D, 4'hF, 128);
        push(LF_D, 4'b0001, 1);
        flush();
        settle();
        check("gap128_link", 32'(link_status), 32'd0);
        check("gap128_lcnt", 32'(stat_local_fault_cnt), 32'd1);
        push(IDLE_D, 4'hF, 128);
        push(LF_D, 4'b0001, 3);
        push(IDLE_D, 4'hF, 127);
        push(LF_D, 4'b0001, 1);
        flush();
        settle();
        check("gap127_link", 32'(link_status), 32'd1);
        check("gap127_lcnt", 32'(stat_local_fault_cnt), 32'd2);

        // LF,LF,RF,RF,RF,RF from a fresh reset
        tb_rst = 1'b1;
        drive(IDLE_D, 4'hF, IDLE_D, 4'hF);
        tb_rst = 1'b0;
        push(LF_D, 4'b0001, 2);
        push(RF_D, 4'b0001, 4);
        flush();
        settle();
        check("mix_link", 32'(link_status), 32'd2);
        check("mix_tx", 32'(tx_fault_mode), 32'd2);
        check("mix_rcnt", 32'(stat_remote_fault_cnt), 32'd1);
        check("mix_lcnt", 32'(stat_local_fault_cnt), 32'd0);

        // Enable dropped inside a three-cycle frame starting in lane 4
        push(IDLE_D, 4'hF, 130);
        flush();
        settle();
        check("pre_frame_rx_en", 32'(rx_enable), 32'd1);
        drive(IDLE_D, 4'hF, {24'h5A_A5_3C, 8'hFB}, 4'b0001);
        settle();
        check("frame_start_rx_en", 32'(rx_enable), 32'd1);
        tb_cfg = 1'b0;
        drive($urandom(), 4'h0, $urandom(), 4'h0);
        settle();
        check("frame_mid_rx_en", 32'(rx_enable), 32'd1);
        drive($urandom(), 4'h0, {16'h0707, 8'hFD, 8'h42}, 4'b1110);
        settle();
        check("frame_after_term_rx_en", 32'(rx_enable), 32'd0);
        tb_cfg = 1'b1;
        drive(IDLE_D, 4'hF, IDLE_D, 4'hF);
        settle();
        check("frame_reenable_rx_en", 32'(rx_enable), 32'd1);

        // Counter saturation, then clear coinciding with a declaration
        for (int i = 0; i < 16; i++) begin
            push(LF_D, 4'b0001, 4);
            push(RF_D, 4'b0001, 4);
        end
        flush();
        settle();
        check("sat_rcnt", 32'(stat_remote_fault_cnt), 32'(CNT_MAX));
        check("sat_lcnt", 32'(stat_local_fault_cnt), 32'(CNT_MAX));
        push(LF_D, 4'b0001, 4);
        flush();
        drive(RF_D, 4'b0001, RF_D, 4'b0001);
        tb_clr = 1'b1;
        drive(RF_D, 4'b0001, RF_D, 4'b0001);
        tb_clr = 1'b0;
        settle();
        check("clr_evt_rcnt", 32'(stat_remote_fault_cnt), 32'd1);
        check("clr_evt_lcnt", 32'(stat_local_fault_cnt), 32'd0);
        check("clr_evt_link", 32'(link_status), 32'd2);

        // Randomized traffic checked every cycle by the compare process
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tb_rst = ($urandom_range(0, 399) == 0);
            tb_clr = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 39) == 0) tb_cfg = ~tb_cfg;
            if ($urandom_range(0, 149) == 0) begin
                for (int k = 0; k < 60 + int'($urandom_range(0, 10)); k++) begin
                    drive(IDLE_D, 4'hF, IDLE_D, 4'hF);
                end
            end else begin
                rand_col(d0, c0);
                rand_col(d1, c1);
                drive(d0, c0, d1, c1);
            end
        end
        tb_rst = 1'b0;
        tb_clr = 1'b0;

        @(posedge clk);
        #4;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
